uart_rx_top: RTL and testbench

- Top-level UART receive path: 8N1 serial receiver at a fixed baud rate, a 4-entry byte FIFO, and a 1 Hz tick generator that drains the FIFO.
- Sits between the board RX pin and on-board indicators (LEDs/7-seg).
- Exposes the last received byte, a frame-active flag, the FIFO write strobe, FIFO-full status, the 1 Hz clock and the active baud-rate code.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_byte_fifo.sv | 41 ++++
 rtl/uart_rx_top.sv | 145 ++++++++++++++
 tb/tb_uart_rx_top.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, RX state encoding and baud divisor helpers
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic int baud_rate(input int code);
    case (code)
      0:       return 9600;
      1:       return 19200;
      2:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clock cycles per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int code);
    return (clk_hz + baud_rate(code) / 2) / baud_rate(code);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - byte queue occupancy tracker with push/pop/full/empty
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        do_push, do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty_o  = (count == '0);
    full_o   = (count == (AW+1)'(DEPTH));
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// rtl/uart_rx_top.sv - UART 8N1 receiver, byte FIFO and 1 Hz drain tick
// Optional: FRAME_ERR_DROP_EN discards frames whose stop bit samples 0.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_SEL   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX,
  output logic [1:0]           oRate,
  output logic                 owSTART,
  output logic [DATA_BITS-1:0] owData,
  output logic                 owClk1s,
  output logic                 oWRen,
  output logic                 oFIFO_FULL
);

  localparam int DIV      = baud_div(CLK_HZ, BAUD_SEL);
  localparam int HALF     = DIV / 2;
  localparam int CW       = $clog2(DIV + 1);
  localparam int HALF_SEC = CLK_HZ / 2;
  localparam int TW       = $clog2(HALF_SEC + 1);

  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 start_q, start_d;
  logic                 wren_q, wren_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 clk1s_q, clk1s_d;
  logic                 tick_rise, fifo_pop, fifo_full, fifo_empty, frame_ok;

`ifdef FRAME_ERR_DROP_EN
  assign frame_ok = rx_sync_q;
`else
  assign frame_ok = 1'b1;
`endif

  assign tick_rise = (tick_q == TW'(HALF_SEC - 1)) && !clk1s_q;
  assign fifo_pop  = tick_rise && !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    start_d = start_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) begin
          state_d = ST_START;
          start_d = 1'b1;
        end
      end
      ST_START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        if (rx_sync_q) begin
          state_d = ST_IDLE;
          start_d = 1'b0;
        end else begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d   = '0;
        shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
      end
      ST_STOP: if (cnt_q == CW'(DIV - 1)) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        start_d = 1'b0;
        if (frame_ok) begin
          data_d = shift_q;
          // A pop this cycle frees the slot the push lands in next cycle.
          wren_d = !fifo_full || fifo_pop;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tick_q == TW'(HALF_SEC - 1)) begin
      tick_d  = '0;
      clk1s_d = !clk1s_q;
    end else begin
      tick_d  = tick_q + TW'(1);
      clk1s_d = clk1s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      wren_q    <= 1'b0;
      tick_q    <= '0;
      clk1s_q   <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      start_q   <= start_d;
      wren_q    <= wren_d;
      tick_q    <= tick_d;
      clk1s_q   <= clk1s_d;
    end
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wren_q),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign oRate      = 2'(BAUD_SEL);
  assign owSTART    = start_q;
  assign owData     = data_q;
  assign owClk1s    = clk1s_q;
  assign oWRen      = wren_q;
  assign oFIFO_FULL = fifo_full;

endmodule

// File: tb/tb_uart_rx_top.sv
// tb/tb_uart_rx_top.sv - scoreboard bench for uart_rx_top with a small clock so the 1 Hz tick is reachable
module tb_uart_rx_top;

  localparam int CLK_HZ   = 76_800;
  localparam int DEPTH    = 4;
  localparam int BIT      = CLK_HZ / 9600;
  localparam int HALF_SEC = CLK_HZ / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1;
  logic [1:0] oRate;
  logic       owSTART, owClk1s, oWRen, oFIFO_FULL;
  logic [7:0] owData;

  uart_rx_top #(.CLK_HZ(CLK_HZ), .BAUD_SEL(0), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX         (RX),
    .oRate      (oRate),
    .owSTART    (owSTART),
    .owData     (owData),
    .owClk1s    (owClk1s),
    .oWRen      (oWRen),
    .oFIFO_FULL (oFIFO_FULL)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_data_q[$];
  logic [7:0] exp_wr_q[$];
  int         occ = 0;
  int         pops_applied = 0;
  logic [7:0] model_last = 8'h00;
  int         frame_start_cyc = 0;
  int         last_wren_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pops_by(input int n);
    return (n >= HALF_SEC) ? (n - HALF_SEC) / (2 * HALF_SEC) + 1 : 0;
  endfunction

  task automatic model_sync();
    while (pops_applied < pops_by(cyc)) begin
      if (occ > 0) occ--;
      pops_applied++;
    end
  endtask

  task automatic check_clk1s();
    check("clk1s", {31'd0, owClk1s}, 32'((cyc / HALF_SEC) % 2));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    int  nxt;
    logic good;
    nxt = HALF_SEC * (2 * pops_by(cyc) + 1);
    if (nxt - cyc < 100) repeat (nxt - cyc + 3) @(negedge clk);
    model_sync();
`ifdef FRAME_ERR_DROP_EN
    good = stop_bit;
`else
    good = 1'b1;
`endif
    if (good) begin
      if (b != model_last) exp_data_q.push_back(b);
      model_last = b;
      if (occ < DEPTH) begin
        occ++;
        exp_wr_q.push_back(b);
      end
    end
    frame_start_cyc = cyc;
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge clk);
      if (i == 3) check("start_active", {31'd0, owSTART}, 32'd1);
    end
    RX = stop_bit;
    repeat (BIT) @(negedge clk);
    RX = 1'b1;
    repeat (gap) @(negedge clk);
    if (gap >= 3) begin
      model_sync();
      check("fifo_full", {31'd0, oFIFO_FULL}, {31'd0, occ == DEPTH});
    end
  endtask

  task automatic monitor_loop();
    logic [7:0] prev = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 8'h00;
      end else begin
        if (owData !== prev) begin
          n_checks++;
          if (exp_data_q.size() == 0) begin
            n_errors++;
            $display("FAIL owdata_change: got %02h expected unchanged %02h", owData, prev);
          end else begin
            e = exp_data_q.pop_front();
            if (owData !== e) begin
              n_errors++;
              $display("FAIL owdata_value: got %02h expected %02h", owData, e);
            end
          end
          prev = owData;
        end
        if (oWRen !== 1'b0) begin
          n_checks++;
          last_wren_cyc = cyc;
          if (exp_wr_q.size() == 0) begin
            n_errors++;
            $display("FAIL wren_unexpected: got pulse with %02h expected none", owData);
          end else begin
            e = exp_wr_q.pop_front();
            if (owData !== e) begin
              n_errors++;
              $display("FAIL wren_byte: got %02h expected %02h", owData, e);
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    int         lat;
    fork
      monitor_loop();
    join_none
    reset = 1'b1;
    RX    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_orate",  {30'd0, oRate}, 32'd0);
    check("rst_start",  {31'd0, owSTART}, 32'd0);
    check("rst_data",   {24'd0, owData}, 32'd0);
    check("rst_wren",   {31'd0, oWRen}, 32'd0);
    check("rst_clk1s",  {31'd0, owClk1s}, 32'd0);
    check("rst_full",   {31'd0, oFIFO_FULL}, 32'd0);
    repeat (5) @(negedge clk);

    send_frame(8'h31, 1'b1, 5);
    lat = last_wren_cyc - frame_start_cyc;
    check("wren_latency_ok", {31'd0, (lat >= 9 * BIT + BIT / 2 - 2) && (lat <= 9 * BIT + BIT / 2 + 3)}, 32'd1);

    send_frame(8'h32, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    send_frame(8'h4D, 1'b1, 5);
    send_frame(8'h35, 1'b1, 0);
    send_frame(8'h46, 1'b1, 5);

    RX = 1'b0;
    repeat (2) @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_start", {31'd0, owSTART}, 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_abort", {31'd0, owSTART}, 32'd0);
    check_clk1s();

    while (cyc < HALF_SEC + 10) @(negedge clk);
    check_clk1s();
    model_sync();
    check("full_after_tick", {31'd0, oFIFO_FULL}, {31'd0, occ == DEPTH});

    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, int'($urandom_range(0, 6)));
    end
    send_frame(8'hA5, 1'b0, 12);
    send_frame(8'($urandom), 1'b1, 5);

    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (BIT) @(negedge clk);
    end
    reset = 1'b1;
    RX    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    occ = 0;
    pops_applied = 0;
    model_last = 8'h00;
    @(negedge clk);
    check("midrst_start", {31'd0, owSTART}, 32'd0);
    check("midrst_data",  {24'd0, owData}, 32'd0);
    check("midrst_full",  {31'd0, oFIFO_FULL}, 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_idle",  {31'd0, owSTART}, 32'd0);
    send_frame(8'h5A, 1'b1, 5);

    repeat (10) @(negedge clk);
    check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);
    check("wren_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
